// File: rtl/sram_pkg.sv
// Shared constants, sequencer state type and logic/voltage conversion helpers
// for the banked SRAM cell array.
package sram_pkg;

  localparam real VDD = 1.5;
  localparam real VSS = 0.0;
  localparam real VTH = 0.8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_ACT,
    S_SNS
  } seq_state_e;

  function automatic real l2r(input logic b);
    return b ? VDD : VSS;
  endfunction

  function automatic logic r2l(input real v);
    return v >= VTH;
  endfunction

endpackage

// File: rtl/sram_seq.sv
// Access sequencer: walks precharge, wordline and sense phases and emits
// registered one-per-phase strobes plus the write-commit strobe.
import sram_pkg::*;

module sram_seq #(
  parameter int PRE_CYC = 2,
  parameter int WL_CYC  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic is_write_i,
  output logic ready_o,
  output logic pre_o,
  output logic act_o,
  output logic sns_o,
  output logic commit_o
);

  localparam int MAXC = (PRE_CYC > WL_CYC) ? PRE_CYC : WL_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  seq_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic          ready_q, pre_q, act_q, sns_q, commit_q;

  // NOTE: non-blocking assignments make every register below update from
  // pre-edge values, so the order of statements inside the block is irrelevant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      pre_q    <= 1'b0;
      act_q    <= 1'b0;
      sns_q    <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q <= S_PRE;
            cnt_q   <= CW'(PRE_CYC - 1);
            ready_q <= 1'b0;
            pre_q   <= 1'b1;
          end
        end
        S_PRE: begin
          if (cnt_q == '0) begin
            state_q  <= S_ACT;
            cnt_q    <= CW'(WL_CYC - 1);
            pre_q    <= 1'b0;
            act_q    <= 1'b1;
            commit_q <= is_write_i && (WL_CYC == 1);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_ACT: begin
          if (cnt_q == '0) begin
            act_q    <= 1'b0;
            commit_q <= 1'b0;
            if (is_write_i) begin
              state_q <= S_IDLE;
              ready_q <= 1'b1;
            end else begin
              state_q <= S_SNS;
              sns_q   <= 1'b1;
            end
          end else begin
            cnt_q    <= cnt_q - 1'b1;
            // commit is high exactly during the final wordline cycle of a write
            commit_q <= is_write_i && (cnt_q == CW'(1));
          end
        end
        S_SNS: begin
          state_q <= S_IDLE;
          sns_q   <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o  = ready_q;
  assign pre_o    = pre_q;
  assign act_o    = act_q;
  assign sns_o    = sns_q;
  assign commit_o = commit_q;

endmodule

// File: rtl/banked_cell_array.sv
// Banked SRAM cell array: request latch, per-bank storage, row decode and
// real-valued wordline/bitline drive toward the analog periphery.
import sram_pkg::*;

module banked_cell_array #(
  parameter int ROWS    = 16,
  parameter int COLS    = 8,
  parameter int BANKS   = 2,
  parameter int PRE_CYC = 2,
  parameter int WL_CYC  = 2,
  parameter int AW      = $clog2(ROWS * BANKS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req,
  input  logic            we,
  input  logic [AW-1:0]   addr,
  input  logic [COLS-1:0] wdata,
  input  logic [COLS-1:0] wmask,
  output logic            ready,
  output logic            rvalid,
  output logic [COLS-1:0] rdata,
  output logic            err,
  output real             wl  [0:BANKS*ROWS-1],
  output real             bl  [0:COLS-1],
  output real             blb [0:COLS-1]
);

  localparam int WORDS = ROWS * BANKS;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int BW    = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic            in_range, accept;
  logic [AW-1:0]   addr_q;
  logic            we_q, err_q, rvalid_q;
  logic [COLS-1:0] wdata_q, wmask_q, rdata_q, sense_q;
  logic [BW-1:0]   bank_idx;
  logic [RW-1:0]   row_idx;
  logic [COLS-1:0] stored, merged, drive_word;
  logic            pre, act, sns, commit;

  logic [COLS-1:0] mem_q [BANKS][ROWS];

  assign in_range = int'(addr) < WORDS;
  assign accept   = req && ready && in_range;

  sram_seq #(
    .PRE_CYC (PRE_CYC),
    .WL_CYC  (WL_CYC)
  ) u_seq (
    .clk        (clk),
    .rst        (rst),
    .start_i    (accept),
    .is_write_i (we_q),
    .ready_o    (ready),
    .pre_o      (pre),
    .act_o      (act),
    .sns_o      (sns),
    .commit_o   (commit)
  );

  assign bank_idx   = BW'(int'(addr_q) / ROWS);
  assign row_idx    = RW'(int'(addr_q) % ROWS);
  assign stored     = mem_q[bank_idx][row_idx];
  assign merged     = (stored & ~wmask_q) | (wdata_q & wmask_q);
  assign drive_word = we_q ? merged : stored;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      sense_q  <= '0;
    end else begin
      err_q    <= req && ready && !in_range;
      rvalid_q <= sns;
      if (accept) begin
        addr_q  <= addr;
        we_q    <= we;
        wdata_q <= wdata;
        wmask_q <= wmask;
      end
      // Bitlines are back at VDD during sense, so the word is captured while
      // the wordline is still open and presented at the end of the sense cycle.
      if (pre) begin
        sense_q <= '0;
      end else if (act && !we_q) begin
        for (int c = 0; c < COLS; c++) sense_q[c] <= r2l(bl[c]);
      end
      if (sns) rdata_q <= sense_q;
    end
  end

  // NOTE: the cell array has no reset; its contents must survive rst, and
  // clearing a whole memory on reset would also prevent RAM inference.
  always_ff @(posedge clk) begin
    if (commit) mem_q[bank_idx][row_idx] <= merged;
  end

  // NOTE: every analog output receives its idle level first, so no path through
  // this block can leave a value unassigned and infer a latch.
  always_comb begin
    for (int i = 0; i < WORDS; i++) wl[i] = VSS;
    for (int c = 0; c < COLS; c++) begin
      bl[c]  = VDD;
      blb[c] = VDD;
    end
    if (act) begin
      wl[WW'(addr_q)] = VDD;
      for (int c = 0; c < COLS; c++) begin
        bl[c]  = l2r(drive_word[c]);
        blb[c] = l2r(!drive_word[c]);
      end
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign err    = err_q;

endmodule

// File: tb/tb_banked_cell_array.sv
// Randomized self-checking bench for banked_cell_array against a word-level
// memory model and a phase-by-cycle timing model.
module tb_banked_cell_array;

  localparam int ROWS  = 16;
  localparam int COLS  = 8;
  localparam int BANKS = 2;
  localparam int P     = 2;
  localparam int W     = 2;
  localparam int WORDS = ROWS * BANKS;
  // One spare address bit so that addresses past the last word can be driven.
  localparam int AW    = $clog2(WORDS) + 1;
  localparam real V_HI = 1.5;
  localparam real V_LO = 0.0;

  logic            clk, rst, req, we;
  logic [AW-1:0]   addr;
  logic [COLS-1:0] wdata, wmask;
  logic            ready, rvalid, err;
  logic [COLS-1:0] rdata;
  real             wl  [0:WORDS-1];
  real             bl  [0:COLS-1];
  real             blb [0:COLS-1];

  int              checks, errors;
  logic [7:0]      model [WORDS];
  logic [7:0]      last_rd;

  banked_cell_array #(
    .ROWS    (ROWS),
    .COLS    (COLS),
    .BANKS   (BANKS),
    .PRE_CYC (P),
    .WL_CYC  (W),
    .AW      (AW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .wmask  (wmask),
    .ready  (ready),
    .rvalid (rvalid),
    .rdata  (rdata),
    .err    (err),
    .wl     (wl),
    .bl     (bl),
    .blb    (blb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {lines at 1.5 V, lines at 0.0 V}
  function automatic logic [63:0] wl_code();
    logic [31:0] hi, lo;
    hi = '0;
    lo = '0;
    for (int i = 0; i < WORDS; i++) begin
      hi[i] = (wl[i] == V_HI);
      lo[i] = (wl[i] == V_LO);
    end
    return {hi, lo};
  endfunction

  function automatic logic [63:0] exp_wl(input int a, input bit on);
    logic [31:0] hi;
    hi = on ? (32'd1 << a) : 32'd0;
    return {hi, ~hi};
  endfunction

  // {bl at 1.5, bl at 0.0, blb at 1.5, blb at 0.0}
  function automatic logic [63:0] bl_code();
    logic [7:0] bh, bo, ch, co;
    for (int c = 0; c < COLS; c++) begin
      bh[c] = (bl[c] == V_HI);
      bo[c] = (bl[c] == V_LO);
      ch[c] = (blb[c] == V_HI);
      co[c] = (blb[c] == V_LO);
    end
    return {32'd0, bh, bo, ch, co};
  endfunction

  function automatic logic [63:0] exp_bl(input logic [7:0] word, input bit on);
    if (on) return {32'd0, word, ~word, ~word, word};
    return {32'd0, 8'hFF, 8'h00, 8'hFF, 8'h00};
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, ready, 1);
    check({tag, "_rvalid"}, rvalid, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_wl"}, wl_code(), exp_wl(0, 0));
    check({tag, "_bl"}, bl_code(), exp_bl(8'h00, 0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 1'b0;
    #1;
    check_reset_state("rst");
    last_rd = 8'h00;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issues one request at the current negedge and checks every following cycle
  // until the array is idle again. rst_at > 0 asserts reset in that cycle.
  task automatic run_access(input bit w, input int a, input logic [7:0] d,
                            input logic [7:0] m, input int rst_at, input bit keep);
    logic [7:0] word;
    logic [4:0] ai;
    int         last;
    bit         act_ph, done;
    check("rdy_before", ready, 1);
    req   = 1'b1;
    we    = w;
    addr  = AW'(a);
    wdata = d;
    wmask = m;
    @(posedge clk);
    if (a >= WORDS) begin
      @(negedge clk);
      req = 1'b0;
      check("oor_err", err, 1);
      check("oor_ready", ready, 1);
      check("oor_rvalid", rvalid, 0);
      check("oor_wl", wl_code(), exp_wl(0, 0));
      check("oor_bl", bl_code(), exp_bl(8'h00, 0));
      @(negedge clk);
      check("oor_err_end", err, 0);
      check("oor_ready2", ready, 1);
      return;
    end
    ai   = 5'(a);
    word = w ? ((model[ai] & ~m) | (d & m)) : model[ai];
    last = w ? P + W + 1 : P + W + 2;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (k == 1 && !keep) req = 1'b0;
      if (k == rst_at) begin
        rst = 1'b1;
        #1;
        check_reset_state("rst_mid");
        last_rd = 8'h00;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        req = 1'b0;
        return;
      end
      act_ph = (k > P) && (k <= P + W);
      done   = (k == last);
      check("ready", ready, done);
      check("rvalid", rvalid, !w && done);
      check("err", err, 0);
      check("wl", wl_code(), exp_wl(a, act_ph));
      check("bl", bl_code(), exp_bl(word, act_ph));
      if (!w && done) last_rd = word;
      check("rdata", rdata, last_rd);
    end
    if (w) model[ai] = word;
  endtask

  initial begin
    int a, ra;
    bit w;
    logic [7:0] d, m;
    checks  = 0;
    errors  = 0;
    last_rd = 8'h00;
    rst   = 1'b1;
    req   = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    wmask = '0;
    repeat (2) @(negedge clk);
    check_reset_state("por");
    rst = 1'b0;

    // give every word a known value
    for (int i = 0; i < WORDS; i++) run_access(1, i, 8'($urandom), 8'hFF, 0, 0);

    // write/read, masked write into bank 1, last address
    run_access(1, 0, 8'hA5, 8'hFF, 0, 0);
    run_access(0, 0, 8'h00, 8'h00, 0, 0);
    run_access(1, 17, 8'h00, 8'hFF, 0, 0);
    run_access(1, 17, 8'hFF, 8'h0F, 0, 0);
    run_access(0, 17, 8'h00, 8'h00, 0, 0);
    run_access(1, WORDS - 1, 8'h5A, 8'hFF, 0, 0);
    run_access(0, WORDS - 1, 8'h00, 8'h00, 0, 0);
    run_access(1, 7, 8'hFF, 8'h00, 0, 0);
    run_access(0, 7, 8'h00, 8'h00, 0, 0);

    // out-of-range request leaves state and storage alone
    run_access(0, 32, 8'h00, 8'h00, 0, 0);
    run_access(0, 0, 8'h00, 8'h00, 0, 0);

    // reset during the second wordline cycle of a write discards it
    run_access(1, 3, 8'h3C, 8'hFF, P + 2, 0);
    run_access(0, 3, 8'h00, 8'h00, 0, 0);

    // req held high: back-to-back reads accepted only when ready
    run_access(0, 5, 8'h00, 8'h00, 0, 1);
    run_access(0, 6, 8'h00, 8'h00, 0, 1);
    req = 1'b0;

    // contents survive reset
    run_access(1, 9, 8'hC3, 8'hFF, 0, 0);
    do_reset();
    run_access(0, 9, 8'h00, 8'h00, 0, 0);

    for (int n = 0; n < 200; n++) begin
      w  = 1'($urandom);
      a  = int'($urandom_range(0, WORDS + 3));
      d  = 8'($urandom);
      m  = 8'($urandom);
      if ($urandom_range(0, 7) == 0) m = 8'h00;
      ra = 0;
      if (a < WORDS && $urandom_range(0, 9) == 0) ra = int'($urandom_range(1, P + W));
      run_access(w, a, d, m, ra, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/banked_cell_array.md
Name: banked_cell_array

Overview:
Parametrised successor of the flat real-valued SRAM cell array. It adds banking, a clocked access sequencer (precharge, wordline pulse, sense), a req/ready handshake and per-bit write masking. Analog-facing wordline and bitline levels are driven as real voltages (VDD 1.5, VSS 0.0, VTH 0.8). The block sits between the digital memory controller and the analog periphery models.

Parameters:
ROWS, 16, rows per bank
COLS, 8, bits per word (columns)
BANKS, 2, number of banks; total words = ROWS*BANKS
PRE_CYC, 2, precharge duration in cycles (>=1)
WL_CYC, 2, wordline-asserted duration in cycles (>=1)
AW, $clog2(ROWS*BANKS), address width

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
req  in  1  access request; accepted when req && ready
we  in  1  1 = write, 0 = read; sampled at accept
addr  in  AW  word address; bank = addr / ROWS, row = addr % ROWS
wdata  in  COLS  write data, sampled at accept
wmask  in  COLS  per-bit write enable, sampled at accept
ready  out  1  high only in IDLE
rvalid  out  1  one-cycle pulse with read data
rdata  out  COLS  sensed read word, held until next read
err  out  1  one-cycle pulse for an out-of-range address (addr >= ROWS*BANKS)
wl  out  real [0:BANKS*ROWS-1]  wordline voltages, VDD when active, else VSS
bl  out  real [0:COLS-1]  bitline voltages of the active bank
blb  out  real [0:COLS-1]  complementary bitline voltages

Behaviour:
- Reset (async assert): state IDLE, ready=1, rvalid=0, err=0, rdata=0, all wl=VSS, all bl/blb=VDD. Storage is not cleared and its contents survive reset.
- Storage: per-bank logic array [ROWS][COLS]. Bit value b maps to bl = b ? VDD : VSS and blb = the inverse.
- FSM states: IDLE, PRE, ACT, SNS.
- IDLE -> PRE on req && in-range addr. The request fields are latched and ready drops next cycle.
- IDLE with req && out-of-range addr: err pulses 1 the next cycle, state stays IDLE, and storage and analog outputs are unchanged.
- PRE lasts PRE_CYC cycles: bl/blb=VDD, wl all VSS. Then -> ACT.
- ACT lasts WL_CYC cycles: wl[addr] = VDD and all others VSS.
  - Read: bl/blb driven with stored bits.
  - Write: bl/blb driven with merged data (wmask ? wdata : stored).
  - A write commits to storage at the clock edge ending the last ACT cycle, then -> IDLE.
  - A read goes -> SNS.
- SNS lasts 1 cycle: wl all VSS, rdata[c] = (bl[c] >= VTH). rvalid pulses in the cycle after SNS, and the state returns to IDLE in that same cycle.
- Read latency: accept edge to rvalid = PRE_CYC + WL_CYC + 2 cycles.
- Write occupancy: ready returns PRE_CYC + WL_CYC + 1 cycles after accept.
- Bitlines idle at VDD in IDLE and SNS.
- Requests are ignored while ready=0; nothing is queued.
- Reset mid-operation:
  - A write whose final ACT edge has not yet occurred is discarded and the row is unchanged.
  - A read in flight is dropped and no rvalid is produced.
- wmask=0 write: the full sequence runs and storage is unchanged.
- Address wrap: the last address ROWS*BANKS-1 is legal. No wrap-around is performed.

Decomposition:
- Package sram_pkg holds:
  - real constants VDD, VSS, VTH
  - the state enum typedef
  - the functions l2r (logic to real) and r2l (real to logic against VTH)
- Sub-module sram_seq holds the FSM and cycle counters and outputs phase strobes: pre, act, sns, commit.
- The top level holds storage, decode and analog drive.

Test Plan:
1. Reset, then write addr=0 wdata=8'hA5 wmask=8'hFF, then read addr=0 -> rvalid at accept+6 (defaults), rdata=8'hA5. During ACT of the write, bl[0]=1.5 and blb[0]=0.0.
2. Write addr=17 (bank1, row1) wdata=8'hFF wmask=8'h0F over prior 8'h00 -> read addr=17 gives 8'h0F. Throughout ACT only wl[17]=1.5.
3. req with addr=32 -> err pulses one cycle, ready stays 1, all wl=0.0, and a later read of addr=0 is unaffected.
4. Issue write addr=3 8'h3C, then assert rst during the 2nd ACT cycle -> wl all 0.0, bl all 1.5, ready=1; a read of addr=3 returns the old value.
5. Hold req high for back-to-back reads of addr 5 and 6 -> second accept occurs only when ready=1. There is exactly one rvalid per accept, and ready is low for 5 cycles after each accept.
6. Write then reset then read the same address -> data is preserved across reset.
